// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared UART constants used by the receive FIFO and by the memory-map status
// decode that reads Count / OutValid / Overflow.
//   UART_BYTE_W     : width of one UART character
//   RX_FIFO_DEPTH   : default receive FIFO depth (entries)
//   RX_FIFO_PTR_W   : pointer / occupancy width for the default depth
//   fifo_ptr_w()    : pointer width for an arbitrary depth (index bits + wrap bit)
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_BYTE_W   = 8;
    localparam int RX_FIFO_DEPTH = 8;

    // One extra bit beyond the index lets full and empty be told apart
    // without a separate occupancy flag.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int RX_FIFO_PTR_W = fifo_ptr_w(RX_FIFO_DEPTH);

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_mem.sv
// ----------------------------------------------------------------------------
// fifo_mem
// WIDTH x DEPTH register array: synchronous write, asynchronous read.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : combinational read of the addressed entry
// ----------------------------------------------------------------------------
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; entries are only ever read after being
    // written, and leaving it out keeps it a plain register file.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : fifo_mem

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
// Receive byte buffer between the UART receiver and the CPU load path.
// Stores up to DEPTH bytes in arrival order and presents the oldest one
// first-word-fall-through. Bytes arriving while full are dropped and flagged
// through a sticky Overflow bit.
//   Clock, Reset    : clock; asynchronous active-high reset
//   InData, InValid : byte from the UART and its valid
//   InReady         : to UART DataOutReady; 0 in reset, 1 otherwise
//   OutData         : oldest byte (0 while empty)
//   OutValid        : FIFO non-empty
//   OutReady        : datapath pop strobe
//   Count           : occupancy 0..DEPTH
//   Overflow        : sticky drop flag
//   ClearOverflow   : synchronous clear of Overflow (a same-cycle drop wins)
// ----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH,
    parameter int WIDTH = UART_BYTE_W
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [WIDTH-1:0]       InData,
    input  logic                   InValid,
    output logic                   InReady,
    output logic [WIDTH-1:0]       OutData,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Overflow,
    input  logic                   ClearOverflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = fifo_ptr_w(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             in_ready_q, in_ready_d;

    logic             empty, full;
    logic             push, pop, drop;
    logic [WIDTH-1:0] rd_data;

    // Equal pointers mean empty; same index with opposite wrap bits means the
    // writer is exactly one lap ahead, i.e. full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // NOTE: every signal gets its default before any condition so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        pop        = 1'b0;
        push       = 1'b0;
        drop       = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        in_ready_d = 1'b1;

        // A pop on an empty FIFO is ignored, which also makes a same-cycle
        // push+pop on empty a plain push.
        pop  = OutReady & ~empty;
        // At full, a concurrent pop frees the slot the push needs.
        push = InValid & in_ready_q & (~full | pop);
        drop = InValid & in_ready_q & full & ~pop;

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);

        if (drop) begin
            overflow_d = 1'b1;
        end else if (ClearOverflow) begin
            overflow_d = 1'b0;
        end
    end

    // Occupancy is derived from the next pointers so it can never drift
    // from them; modulo 2*DEPTH arithmetic handles the wrap for free.
    assign count_d = wr_ptr_d - rd_ptr_d;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            in_ready_q <= in_ready_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (Clock),
        .we    (push),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (InData),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_data)
    );

    // Stale array contents are masked while empty so the bus reads 0 out of
    // reset and after draining.
    assign OutData  = empty ? '0 : rd_data;
    assign OutValid = ~empty;
    assign Count    = count_q;
    assign Overflow = overflow_q;
    assign InReady  = in_ready_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo (DEPTH=8, WIDTH=8). A queue-based
// reference model tracks contents, overflow and InReady.
// ----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             Clock;
    logic             Reset;
    logic [WIDTH-1:0] InData;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] OutData;
    logic             OutValid;
    logic             OutReady;
    logic [CW-1:0]    Count;
    logic             Overflow;
    logic             ClearOverflow;

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .InData        (InData),
        .InValid       (InValid),
        .InReady       (InReady),
        .OutData       (OutData),
        .OutValid      (OutValid),
        .OutReady      (OutReady),
        .Count         (Count),
        .Overflow      (Overflow),
        .ClearOverflow (ClearOverflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state
    logic [WIDTH-1:0] mq[$];
    logic             model_ov;
    logic             model_rdy;

    typedef struct {
        logic             iv;
        logic [WIDTH-1:0] id;
        logic             ordy;
        logic             clr;
        logic             exp_valid;
        logic [WIDTH-1:0] exp_data;
        logic [CW-1:0]    exp_count;
        logic             exp_ov;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        model_ov  = 1'b0;
        model_rdy = 1'b0;
    endtask

    // One clock edge of the buffer's behaviour, stated as queue operations.
    task automatic model_step(input logic iv, input logic [WIDTH-1:0] d,
                              input logic ordy, input logic clr);
        logic pop_m, full_m, drop_m;
        pop_m  = ordy && (mq.size() > 0);
        full_m = (mq.size() == DEPTH);
        drop_m = 1'b0;
        if (pop_m) void'(mq.pop_front());
        if (iv && model_rdy) begin
            if (!full_m || pop_m) mq.push_back(d);
            else                  drop_m = 1'b1;
        end
        if (drop_m)   model_ov = 1'b1;
        else if (clr) model_ov = 1'b0;
        model_rdy = 1'b1;
    endtask

    // Present inputs for one edge, advance the model, return 1 time unit
    // after the edge with inputs idle.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] d,
                         input logic ordy, input logic clr);
        InValid       = iv;
        InData        = d;
        OutReady      = ordy;
        ClearOverflow = clr;
        @(posedge Clock);
        model_step(iv, d, ordy, clr);
        #1;
        InValid       = 1'b0;
        OutReady      = 1'b0;
        ClearOverflow = 1'b0;
    endtask

    task automatic check_model(input string name);
        logic [WIDTH-1:0] exp_d;
        exp_d = (mq.size() > 0) ? mq[0] : '0;
        check({name, ".valid"},    32'(OutValid), 32'(mq.size() > 0));
        check({name, ".data"},     32'(OutData),  32'(exp_d));
        check({name, ".count"},    32'(Count),    32'(mq.size()));
        check({name, ".overflow"}, 32'(Overflow), 32'(model_ov));
        check({name, ".inready"},  32'(InReady),  32'(model_rdy));
    endtask

    task automatic mcycle(input string name, input logic iv, input logic [WIDTH-1:0] d,
                          input logic ordy, input logic clr);
        cycle(iv, d, ordy, clr);
        check_model(name);
    endtask

    initial begin
        // Fill/drain, overflow, simultaneous-at-full and empty push+pop.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 8'(8'h41 + i), 1'b0, 1'b0, 1'b1, 8'h41, CW'(i + 1), 1'b0};
        tbl[8]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h41, CW'(8), 1'b1}; // drop
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h41, CW'(8), 1'b0}; // clear
        tbl[10] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 8'h42, CW'(8), 1'b0}; // push+pop full
        for (int i = 0; i < 6; i++)
            tbl[11 + i] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'(8'h43 + i), CW'(7 - i), 1'b0};
        tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h77, CW'(1), 1'b0};
        tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, CW'(0), 1'b0};
        tbl[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, CW'(0), 1'b0}; // pop on empty
        tbl[20] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h33, CW'(1), 1'b0}; // push+pop empty
        tbl[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, CW'(0), 1'b0};

        // ---------------- reset then idle ----------------
        Reset = 1'b1; InValid = 1'b0; InData = '0; OutReady = 1'b0; ClearOverflow = 1'b0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        check("reset.inready", 32'(InReady), 32'd0);
        check("reset.count",   32'(Count),   32'd0);
        check("reset.outdata", 32'(OutData), 32'd0);
        #2 Reset = 1'b0;
        mcycle("idle0", 1'b0, '0, 1'b0, 1'b0);
        mcycle("idle_pop1", 1'b0, '0, 1'b1, 1'b0);
        mcycle("idle_pop2", 1'b0, '0, 1'b1, 1'b0);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            cycle(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].clr);
            check($sformatf("vec%0d.valid", i),    32'(OutValid), 32'(tbl[i].exp_valid));
            check($sformatf("vec%0d.data", i),     32'(OutData),  32'(tbl[i].exp_data));
            check($sformatf("vec%0d.count", i),    32'(Count),    32'(tbl[i].exp_count));
            check($sformatf("vec%0d.overflow", i), 32'(Overflow), 32'(tbl[i].exp_ov));
        end

        // ---------------- drop and clear in the same cycle: set wins --------
        for (int i = 0; i < DEPTH; i++) mcycle("fill2", 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        mcycle("drop_clr", 1'b1, 8'hEE, 1'b0, 1'b1);
        check("drop_clr.ov_set", 32'(Overflow), 32'd1);
        mcycle("clr", 1'b0, '0, 1'b0, 1'b1);

        // ---------------- wrap: 20 simultaneous push/pop ----------------
        for (int i = 0; i < DEPTH - 1; i++) mcycle("drain", 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) mcycle($sformatf("wrap%0d", i), 1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);

        // ---------------- randomized against model ----------------
        for (int i = 0; i < 400; i++) begin
            int pin;
            logic iv, ordy, clr;
            pin  = ((i / 40) % 2 == 1) ? 85 : 30;
            iv   = ($urandom_range(99) < pin);
            ordy = ($urandom_range(99) < 100 - pin);
            clr  = ($urandom_range(15) == 0);
            mcycle($sformatf("rnd%0d", i), iv, 8'($urandom), ordy, clr);
        end

        // ---------------- async reset mid-stream ----------------
        while (mq.size() > 0) mcycle("pre_drain", 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) mcycle("fill3", 1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        mcycle("drop3", 1'b1, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) mcycle("pop3", 1'b0, '0, 1'b1, 1'b0);
        check("pre_reset.count", 32'(Count), 32'd5);
        #2 Reset = 1'b1;
        #1;
        check("arst.count",    32'(Count),    32'd0);
        check("arst.valid",    32'(OutValid), 32'd0);
        check("arst.overflow", 32'(Overflow), 32'd0);
        check("arst.inready",  32'(InReady),  32'd0);
        check("arst.outdata",  32'(OutData),  32'd0);
        InValid = 1'b1; InData = 8'hEE;           // byte lost under reset
        @(posedge Clock);
        #2 InValid = 1'b0; Reset = 1'b0;
        model_reset();
        check("rel.count", 32'(Count), 32'd0);
        mcycle("rel_edge", 1'b0, '0, 1'b0, 1'b0);
        mcycle("push11", 1'b1, 8'h11, 1'b0, 1'b0);
        check("push11.head", 32'(OutData), 32'h11);
        mcycle("pop11", 1'b0, '0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_uart_rx_fifo
